// File: rtl/jtopl_eg_kon_if.sv
// Key-on write port and per-slot key-edge presentation bus for jtopl_eg_kon.
// Latency: n/a (signal bundle only).
// Backpressure: none; the bus is qualified by the block's clock enable.
//
// Signals:
//   up_kon     key-on register write strobe
//   kon_ch     channel index of the write
//   kon_val    key-on value written
//   slot       slot index whose key edges are currently presented
//   zero       high while slot == 0
//   keyon_now  rising key edge for the presented slot
//   keyoff_now falling key edge for the presented slot
//   eg_cnt     global envelope counter
interface jtopl_eg_kon_if #(
  parameter int CNT_W = 15
);
  logic             up_kon;
  logic [3:0]       kon_ch;
  logic             kon_val;
  logic [4:0]       slot;
  logic             zero;
  logic             keyon_now;
  logic             keyoff_now;
  logic [CNT_W-1:0] eg_cnt;

  modport slave (
    input  up_kon, kon_ch, kon_val,
    output slot, zero, keyon_now, keyoff_now, eg_cnt
  );

  modport master (
    output up_kon, kon_ch, kon_val,
    input  slot, zero, keyon_now, keyoff_now, eg_cnt
  );
endinterface

// File: rtl/jtopl_eg_kon.sv
// Key-on tracking: turns per-channel key-on levels into per-slot key-on/key-off pulses.
// Latency: a slot is presented one enabled cycle after it is evaluated.
// Backpressure: none; all state advances only on cen, and outputs hold while cen=0.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   cen         clock enable; slot advance, key evaluation and counter update
//   bus         jtopl_eg_kon_if.slave: key-on writes in, slot/edge/eg_cnt out
//
// Slot s < NCH is operator 1 of channel s, slot s >= NCH is operator 2 of
// channel s-NCH. Each slot compares the channel level once per frame against
// the level it saw last frame, so glitches between evaluations are invisible.
module jtopl_eg_kon #(
  parameter int NCH   = 9,
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  jtopl_eg_kon_if.slave    bus
);

  localparam int         NSLOT     = 2 * NCH;
  localparam logic [4:0] NCH5      = 5'(NCH);
  localparam logic [4:0] LAST_SLOT = 5'(NSLOT - 1);

  logic [NCH-1:0]   kon;
  logic [NSLOT-1:0] last;
  logic [4:0]       cnt;       // slot evaluated on the next enabled edge
  logic [4:0]       ch;
  logic             cur;
  logic             prev;

  // Channel level and last-seen level for the slot under evaluation.
  // Registered kon is read here, so a write on the same edge is only seen
  // by this slot in the following frame.
  always_comb begin
    ch   = (cnt < NCH5) ? cnt : cnt - NCH5;
    cur  = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 5'(i)) cur = kon[i];
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (cnt == 5'(i)) prev = last[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kon            <= '0;
      last           <= '0;
      cnt            <= '0;
      bus.eg_cnt     <= '0;
      bus.slot       <= '0;
      bus.keyon_now  <= 1'b0;
      bus.keyoff_now <= 1'b0;
    end else if (cen) begin
      // Out-of-range channel indices match no bit and are dropped.
      for (int i = 0; i < NCH; i++) begin
        if (bus.up_kon && ({1'b0, bus.kon_ch} == 5'(i))) kon[i] <= bus.kon_val;
      end
      for (int i = 0; i < NSLOT; i++) begin
        if (cnt == 5'(i)) last[i] <= cur;
      end
      bus.keyon_now  <= cur & ~prev;
      bus.keyoff_now <= ~cur & prev;
      bus.slot       <= cnt;
      if (cnt == LAST_SLOT) begin
        cnt        <= '0;
        bus.eg_cnt <= bus.eg_cnt + CNT_W'(1);
      end else begin
        cnt <= cnt + 5'd1;
      end
    end
  end

  assign bus.zero = (bus.slot == 5'd0);

endmodule

// File: tb/tb_jtopl_eg_kon.sv
module tb_jtopl_eg_kon;

  logic clk = 1'b0;
  logic rst_n;
  logic cen;
  logic rst2_n;
  logic cen2;

  always #5 clk = ~clk;

  jtopl_eg_kon_if #(.CNT_W(15)) bus ();
  jtopl_eg_kon_if #(.CNT_W(3))  bus2 ();

  jtopl_eg_kon #(.NCH(9), .CNT_W(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  // Small instance so the envelope counter wrap is reachable quickly.
  jtopl_eg_kon #(.NCH(2), .CNT_W(3)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .cen   (cen2),
    .bus   (bus2)
  );

  int passes = 0;
  int total  = 0;
  int on_cnt  [18];
  int off_cnt [18];
  int tot_on, tot_off, both_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    for (int i = 0; i < 18; i++) begin
      on_cnt[i]  = 0;
      off_cnt[i] = 0;
    end
    tot_on = 0; tot_off = 0; both_cnt = 0;
  endtask

  // One enabled edge; outputs sampled 1 time unit after the edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      cen = 1'b1;
      @(posedge clk);
      #1;
      cen = 1'b0;
      bus.up_kon = 1'b0;
      if (bus.keyon_now)  begin on_cnt[bus.slot]++;  tot_on++;  end
      if (bus.keyoff_now) begin off_cnt[bus.slot]++; tot_off++; end
      if (bus.keyon_now && bus.keyoff_now) both_cnt++;
    end
  endtask

  task automatic wr(input int ch, input logic val);
    bus.up_kon  = 1'b1;
    bus.kon_ch  = 4'(ch);
    bus.kon_val = val;
  endtask

  task automatic step2(input int n);
    for (int k = 0; k < n; k++) begin
      cen2 = 1'b1;
      @(posedge clk);
      #1;
      cen2 = 1'b0;
    end
  endtask

  int slot_err;

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    cen = 1'b1; cen2 = 1'b0;
    bus.up_kon = 1'b0; bus.kon_ch = '0; bus.kon_val = 1'b0;
    bus2.up_kon = 1'b0; bus2.kon_ch = '0; bus2.kon_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_slot",   int'(bus.slot), 0);
    check("rst_zero",   int'(bus.zero), 1);
    check("rst_keyon",  int'(bus.keyon_now), 0);
    check("rst_keyoff", int'(bus.keyoff_now), 0);
    check("rst_eg",     int'(bus.eg_cnt), 0);
    cen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle: two frames, slot sequence and envelope counter.
    clr(); slot_err = 0;
    for (int i = 0; i < 36; i++) begin
      run(1);
      if (int'(bus.slot) != i % 18) slot_err++;
      if (bus.zero != (i % 18 == 0)) slot_err++;
    end
    check("idle_slot_seq", slot_err, 0);
    check("idle_pulses", tot_on + tot_off, 0);
    check("idle_eg", int'(bus.eg_cnt), 2);

    // Key-on ch3 written at slot 0.
    clr();
    wr(3, 1'b1);
    run(4);
    check("kon3_slot3_now", int'(bus.keyon_now), 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_slot", int'(bus.slot), 3);
    check("hold_keyon", int'(bus.keyon_now), 1);
    run(14);
    check("kon3_s3", on_cnt[3], 1);
    check("kon3_s12", on_cnt[12], 1);
    check("kon3_tot_on", tot_on, 2);
    check("kon3_tot_off", tot_off, 0);
    clr();
    run(36);
    check("kon3_later", tot_on + tot_off, 0);

    // Key-off ch3.
    clr();
    wr(3, 1'b0);
    run(18);
    check("koff3_s3", off_cnt[3], 1);
    check("koff3_s12", off_cnt[12], 1);
    check("koff3_tot_off", tot_off, 2);
    check("koff3_tot_on", tot_on, 0);
    check("koff3_both", both_cnt, 0);

    // Write ch5 on the edge slot 5 is evaluated.
    clr();
    run(5);
    wr(5, 1'b1);
    run(13);
    check("kon5_s5_same", on_cnt[5], 0);
    check("kon5_s14_same", on_cnt[14], 1);
    clr();
    run(18);
    check("kon5_s5_next", on_cnt[5], 1);
    check("kon5_s14_next", on_cnt[14], 0);
    check("kon5_next_tot", tot_on, 1);

    // 1->0->1 before evaluation, then same-value write.
    clr();
    wr(5, 1'b0);
    run(1);
    wr(5, 1'b1);
    run(17);
    check("glitch_pulses", tot_on + tot_off, 0);
    clr();
    wr(5, 1'b1);
    run(18);
    check("same_val_pulses", tot_on + tot_off, 0);

    // Out-of-range channel is ignored; ch5 must still be on afterwards.
    clr();
    wr(12, 1'b1);
    run(36);
    check("bad_ch_pulses", tot_on + tot_off, 0);
    clr();
    wr(5, 1'b0);
    run(18);
    check("bad_ch_kon5_kept", tot_off, 2);

    // ch0 on, then reset mid-frame.
    clr();
    wr(0, 1'b1);
    run(18);
    check("kon0_s9", on_cnt[9], 1);
    check("kon0_s0_same", on_cnt[0], 0);
    clr();
    run(18);
    check("kon0_s0_next", on_cnt[0], 1);
    run(5);
    check("pre_rst_eg_nonzero", int'(bus.eg_cnt != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_slot", int'(bus.slot), 0);
    check("arst_zero", int'(bus.zero), 1);
    check("arst_eg", int'(bus.eg_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    run(1);
    check("post_rst_first_slot", int'(bus.slot), 0);
    run(35);
    check("post_rst_keyoff", tot_off, 0);
    check("post_rst_keyon", tot_on, 0);

    // Envelope counter wrap on the small instance (4 slots/frame, 3-bit counter).
    @(negedge clk);
    rst2_n = 1'b1;
    step2(28);
    check("eg2_at7", int'(bus2.eg_cnt), 7);
    check("eg2_slot", int'(bus2.slot), 3);
    step2(3);
    check("eg2_hold7", int'(bus2.eg_cnt), 7);
    step2(1);
    check("eg2_wrap0", int'(bus2.eg_cnt), 0);
    step2(4);
    check("eg2_after_wrap", int'(bus2.eg_cnt), 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/jtopl_eg_kon.md
JTOPL_EG_KON -- requirements
Module: jtopl_eg_kon

Interface
REQ-001 SHALL have parameter NCH, default 9, number of channels (legal 1..16); number of slots is 2*NCH.
REQ-002 SHALL have parameter CNT_W, default 15, width of the envelope counter.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port cen, input, 1 bit, clock enable; slot advance, key evaluation and counter update occur only when cen=1.
REQ-006 SHALL have port up_kon, input, 1 bit, key-on register write strobe, sampled when cen=1.
REQ-007 SHALL have port kon_ch, input, 4 bits, channel index of the write.
REQ-008 SHALL have port kon_val, input, 1 bit, written key-on value.
REQ-009 SHALL have port slot, output, 5 bits, index of the slot whose keyon_now/keyoff_now are currently presented.
REQ-010 SHALL have port zero, output, 1 bit, high while slot=0.
REQ-011 SHALL have port keyon_now, output, 1 bit, rising key edge for the presented slot.
REQ-012 SHALL have port keyoff_now, output, 1 bit, falling key edge for the presented slot.
REQ-013 SHALL have port eg_cnt, output, CNT_W bits, global envelope counter for the step stage.

Function
REQ-014 Slot-to-channel map SHALL be fixed: slot s<NCH is operator 1 of channel s; slot s>=NCH is operator 2 of channel s-NCH.
REQ-015 Internal state SHALL be: kon register (NCH bits), per-slot last-key register (2*NCH bits), slot counter, eg_cnt.
REQ-016 On cen=1 with up_kon=1 and kon_ch<NCH, kon[kon_ch] SHALL take kon_val; writes with kon_ch>=NCH SHALL be ignored without side effects.
REQ-017 On each cen=1, slot counter SHALL advance by one, wrapping from 2*NCH-1 to 0.
REQ-018 On each cen=1, for current slot s and cur=kon[ch(s)] (value before any same-edge write), outputs SHALL be registered as keyon_now=cur&~last[s], keyoff_now=~cur&last[s], slot=s; last[s] SHALL take cur.
REQ-019 Output latency SHALL be exactly one enabled cycle from evaluation of slot s to its presentation; outputs SHALL hold while cen=0.
REQ-020 A write to a channel SHALL become visible to each of its two slots at that slot's next evaluation after the write edge; a write on the same edge as a slot's evaluation SHALL be seen one frame later for that slot.
REQ-021 keyon_now and keyoff_now SHALL never both be 1, and each edge SHALL produce exactly one pulse per slot.
REQ-022 Toggling kon 1->0->1 within one frame before a slot is evaluated SHALL produce no pulse for that slot (level compared once per frame).
REQ-023 eg_cnt SHALL increment by one on the cen=1 edge where the slot counter wraps to 0, wrapping from 2^CNT_W-1 to 0 with no skip.
REQ-024 Writing kon_val equal to the stored value SHALL produce no pulse.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear kon, last, slot counter, eg_cnt, keyon_now, keyoff_now; zero SHALL read 1 during reset.
REQ-026 Release of rst_n SHALL be honoured on the next clk edge with cen=1; the first evaluated slot after reset SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL discard pending edges; no keyoff_now SHALL follow reset for previously keyed slots.

Verification
REQ-028 Reset then 36 cen cycles, no writes -> keyon_now=keyoff_now=0 throughout, slot cycles 0..17, eg_cnt=2.
REQ-029 Write ch3=1 at slot 0 -> keyon_now=1 presented exactly once for slot 3 and once for slot 12 in that frame, none in later frames.
REQ-030 Ch3 held on, write ch3=0 -> keyoff_now=1 once for slots 3 and 12, keyon_now=0.
REQ-031 Write ch5=1 on the same edge slot 5 is evaluated -> no pulse for slot 5 this frame, keyon_now for slot 14 this frame, for slot 5 next frame.
REQ-032 Write kon_ch=12 val=1 -> no pulses on any slot, kon unchanged.
REQ-033 Preload eg_cnt to 2^15-1 via 32767 frames -> next wrap gives eg_cnt=0; rst_n pulse mid-frame with ch0 on -> slot=0, eg_cnt=0, no keyoff_now afterward.
